// File: rtl/ex_mdu.sv
// Iterative RV32M multiply/divide unit for the EX stage: shift-add multiply and
// restoring divide on operand magnitudes, one bit per cycle, stalling the pipe until done.
//
// state | meaning
// IDLE  | waiting for an M instruction in EX; captures operands on accept
// CALC  | one multiply/divide iteration per cycle, WIDTH cycles
// DONE  | result valid for one cycle, instruction leaves EX
module ex_mdu #(
    parameter int WIDTH        = 32,
    parameter bit FAST_SPECIAL = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             valid_in,
    input  logic [2:0]       funct3,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             flush,
    output logic             stall,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_DONE
    } state_t;

    state_t             r_state;
    state_t             w_state_nx;
    logic [2:0]         r_f3;
    logic [WIDTH-1:0]   r_b;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic [CW-1:0]      r_cnt;
    logic               r_neg_lo;
    logic               r_neg_hi;
    logic [WIDTH-1:0]   r_result;

    logic               w_accept;
    logic               w_last;
    logic               w_is_div;
    logic               w_a_sgn;
    logic               w_b_sgn;
    logic               w_neg_a;
    logic               w_neg_b;
    logic [WIDTH-1:0]   w_mag_a;
    logic [WIDTH-1:0]   w_mag_b;
    logic               w_b_zero;
    logic               w_ovf;
    logic               w_special;
    logic [WIDTH-1:0]   w_special_res;

    logic [WIDTH:0]     w_madd;
    logic [WIDTH:0]     w_shift;
    logic               w_ge;
    logic [WIDTH-1:0]   w_rem_sub;
    logic [WIDTH-1:0]   w_hi_nx;
    logic [WIDTH-1:0]   w_lo_nx;
    logic [2*WIDTH-1:0] w_prod;
    logic [2*WIDTH-1:0] w_prod_s;
    logic [WIDTH-1:0]   w_quo;
    logic [WIDTH-1:0]   w_rem;
    logic [WIDTH-1:0]   w_final;

    assign stall  = valid_in & ~done & ~flush;
    assign busy   = (r_state == S_CALC);
    assign done   = (r_state == S_DONE);
    assign result = r_result;

    assign w_accept = (r_state == S_IDLE) & valid_in & ~flush;
    assign w_last   = (r_cnt == CW'(WIDTH - 1));

    // Operand signedness: MULH both, MULHSU rs1 only, DIV/REM both, the rest unsigned.
    assign w_is_div = funct3[2];
    assign w_a_sgn  = w_is_div ? ~funct3[0] : (funct3[1:0] == 2'b01 || funct3[1:0] == 2'b10);
    assign w_b_sgn  = w_is_div ? ~funct3[0] : (funct3[1:0] == 2'b01);
    assign w_neg_a  = w_a_sgn & op_a[WIDTH-1];
    assign w_neg_b  = w_b_sgn & op_b[WIDTH-1];
    assign w_mag_a  = w_neg_a ? -op_a : op_a;
    assign w_mag_b  = w_neg_b ? -op_b : op_b;
    assign w_b_zero = (op_b == '0);
    assign w_ovf    = w_is_div & ~funct3[0] & (op_a == {1'b1, {(WIDTH-1){1'b0}}}) & (op_b == '1);

    assign w_special     = FAST_SPECIAL & w_is_div & (w_b_zero | w_ovf);
    assign w_special_res = funct3[1] ? (w_b_zero ? op_a : '0) : (w_b_zero ? '1 : op_a);

    // Multiply: {hi,lo} shifts right, multiplicand added into hi when lo[0] is set.
    assign w_madd = {1'b0, r_hi} + {1'b0, (r_lo[0] ? r_b : {WIDTH{1'b0}})};

    // Divide: hi is the partial remainder, lo shifts the dividend out and the quotient in.
    assign w_shift   = {r_hi, r_lo[WIDTH-1]};
    assign w_ge      = (w_shift >= {1'b0, r_b});
    assign w_rem_sub = w_shift[WIDTH-1:0] - r_b;

    always_comb begin
        w_hi_nx = w_madd[WIDTH:1];
        w_lo_nx = {w_madd[0], r_lo[WIDTH-1:1]};
        if (r_f3[2]) begin
            w_hi_nx = w_ge ? w_rem_sub : w_shift[WIDTH-1:0];
            w_lo_nx = {r_lo[WIDTH-2:0], w_ge};
        end
    end

    assign w_prod   = {w_hi_nx, w_lo_nx};
    assign w_prod_s = r_neg_lo ? -w_prod : w_prod;
    assign w_quo    = r_neg_lo ? -w_lo_nx : w_lo_nx;
    assign w_rem    = r_neg_hi ? -w_hi_nx : w_hi_nx;

    always_comb begin
        w_final = w_prod_s[2*WIDTH-1:WIDTH];
        case (r_f3)
            3'd0:       w_final = w_prod_s[WIDTH-1:0];
            3'd4, 3'd5: w_final = w_quo;
            3'd6, 3'd7: w_final = w_rem;
            default:    w_final = w_prod_s[2*WIDTH-1:WIDTH];
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_nx = w_special ? S_DONE : S_CALC;
                end
            end
            S_CALC: begin
                if (flush) begin
                    w_state_nx = S_IDLE;
                end else if (w_last) begin
                    w_state_nx = S_DONE;
                end
            end
            S_DONE:  w_state_nx = S_IDLE;
            default: w_state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_f3     <= '0;
            r_b      <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_cnt    <= '0;
            r_neg_lo <= 1'b0;
            r_neg_hi <= 1'b0;
            r_result <= '0;
        end else if (w_accept) begin
            r_f3     <= funct3;
            r_b      <= w_mag_b;
            r_hi     <= '0;
            r_lo     <= w_mag_a;
            r_cnt    <= '0;
            // A zero divisor keeps the all-ones quotient unsigned so iteration matches the fast path.
            r_neg_lo <= (w_neg_a ^ w_neg_b) & ~(w_is_div & w_b_zero);
            r_neg_hi <= w_neg_a;
            if (w_special) begin
                r_result <= w_special_res;
            end
        end else if (r_state == S_CALC && !flush) begin
            r_hi  <= w_hi_nx;
            r_lo  <= w_lo_nx;
            r_cnt <= r_cnt + 1'b1;
            if (w_last) begin
                r_result <= w_final;
            end
        end
    end

endmodule

// File: tb/tb_ex_mdu.sv
// Directed bench for ex_mdu: a vector table run against a fast-special and an
// iterate-everything instance, plus flush and mid-operation reset sequences.
module tb_ex_mdu;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        valid_f = 1'b0;
    logic        valid_s = 1'b0;
    logic [2:0]  funct3 = '0;
    logic [31:0] op_a = '0;
    logic [31:0] op_b = '0;
    logic        flush = 1'b0;
    logic        stall_f, busy_f, done_f;
    logic        stall_s, busy_s, done_s;
    logic [31:0] result_f, result_s;

    int n_cmp = 0;
    int n_bad = 0;
    logic [31:0] last_f = '0;

    always #5 clk = ~clk;

    ex_mdu #(.WIDTH(32), .FAST_SPECIAL(1'b1)) u_fast (
        .clk(clk), .rst(rst), .valid_in(valid_f), .funct3(funct3),
        .op_a(op_a), .op_b(op_b), .flush(flush),
        .stall(stall_f), .busy(busy_f), .done(done_f), .result(result_f)
    );

    ex_mdu #(.WIDTH(32), .FAST_SPECIAL(1'b0)) u_slow (
        .clk(clk), .rst(rst), .valid_in(valid_s), .funct3(funct3),
        .op_a(op_a), .op_b(op_b), .flush(flush),
        .stall(stall_s), .busy(busy_s), .done(done_s), .result(result_s)
    );

    typedef struct {
        logic        slow;
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic slow, input logic [2:0] f3,
                                input logic [31:0] a, input logic [31:0] b,
                                input logic [31:0] exp, input int lat);
        vec_t v;
        v.slow = slow; v.f3 = f3; v.a = a; v.b = b; v.exp = exp; v.lat = lat;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    // Issues one op in IDLE and follows it to completion; done is expected lat cycles after accept.
    task automatic run_op(input logic slow, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input int lat);
        int   k;
        logic seen;
        logic stall_ok;
        logic d, s;
        op_a = a; op_b = b; funct3 = f3;
        if (slow) valid_s = 1'b1; else valid_f = 1'b1;
        #1;
        stall_ok = slow ? stall_s : stall_f;
        k = 0;
        seen = 1'b0;
        while (!seen && k < 60) begin
            @(negedge clk);
            k++;
            d = slow ? done_s : done_f;
            s = slow ? stall_s : stall_f;
            if (d) seen = 1'b1;
            else if (!s) stall_ok = 1'b0;
            if (k == 1) begin
                op_a = $urandom; op_b = $urandom; funct3 = 3'($urandom_range(0, 7));
            end
        end
        chk($sformatf("latency f3=%0d a=%h b=%h", f3, a, b), 32'(k), 32'(lat));
        chk("stall held until done", {31'b0, stall_ok}, 32'd1);
        chk("stall at done", {31'b0, (slow ? stall_s : stall_f)}, 32'd0);
        chk($sformatf("result f3=%0d a=%h b=%h", f3, a, b), slow ? result_s : result_f, exp);
        if (!slow) last_f = exp;
        @(negedge clk);
        valid_f = 1'b0; valid_s = 1'b0;
        chk("done one cycle", {31'b0, (slow ? done_s : done_f)}, 32'd0);
    endtask

    initial begin
        logic quiet;

        tbl.push_back(mk(0, 3'd0, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 33));
        tbl.push_back(mk(0, 3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33));
        tbl.push_back(mk(0, 3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 33));
        tbl.push_back(mk(0, 3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 33));
        tbl.push_back(mk(0, 3'd1, 32'h80000000, 32'h80000000, 32'h40000000, 33));
        tbl.push_back(mk(0, 3'd2, 32'h80000000, 32'h80000000, 32'hC0000000, 33));
        tbl.push_back(mk(0, 3'd4, 32'h12345678, 32'h0,        32'hFFFFFFFF, 1));
        tbl.push_back(mk(0, 3'd6, 32'h12345678, 32'h0,        32'h12345678, 1));
        tbl.push_back(mk(0, 3'd5, 32'h12345678, 32'h0,        32'hFFFFFFFF, 1));
        tbl.push_back(mk(0, 3'd7, 32'h12345678, 32'h0,        32'h12345678, 1));
        tbl.push_back(mk(0, 3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1));
        tbl.push_back(mk(0, 3'd6, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1));
        tbl.push_back(mk(0, 3'd5, 32'd100,      32'd7,        32'd14,       33));
        tbl.push_back(mk(0, 3'd7, 32'd100,      32'd7,        32'd2,        33));
        tbl.push_back(mk(0, 3'd4, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 33));
        tbl.push_back(mk(0, 3'd6, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 33));
        tbl.push_back(mk(0, 3'd4, 32'hFFFFFFF9, 32'hFFFFFFFE, 32'd3,        33));
        tbl.push_back(mk(0, 3'd6, 32'hFFFFFFF9, 32'hFFFFFFFE, 32'hFFFFFFFF, 33));
        tbl.push_back(mk(0, 3'd5, 32'h80000000, 32'hFFFFFFFF, 32'd0,        33));
        tbl.push_back(mk(0, 3'd7, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 33));
        tbl.push_back(mk(0, 3'd4, 32'hFFFFFFF9, 32'h0,        32'hFFFFFFFF, 1));
        tbl.push_back(mk(0, 3'd6, 32'hFFFFFFF9, 32'h0,        32'hFFFFFFF9, 1));
        tbl.push_back(mk(1, 3'd4, 32'h12345678, 32'h0,        32'hFFFFFFFF, 33));
        tbl.push_back(mk(1, 3'd6, 32'h12345678, 32'h0,        32'h12345678, 33));
        tbl.push_back(mk(1, 3'd4, 32'hFFFFFFF9, 32'h0,        32'hFFFFFFFF, 33));
        tbl.push_back(mk(1, 3'd6, 32'hFFFFFFF9, 32'h0,        32'hFFFFFFF9, 33));
        tbl.push_back(mk(1, 3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 33));
        tbl.push_back(mk(1, 3'd6, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 33));
        tbl.push_back(mk(1, 3'd0, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 33));

        #1;
        chk("reset busy", {31'b0, busy_f}, 32'd0);
        chk("reset done", {31'b0, done_f}, 32'd0);
        chk("reset result", result_f, 32'd0);
        chk("reset result slow", result_s, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < tbl.size(); i++) begin
            run_op(tbl[i].slow, tbl[i].f3, tbl[i].a, tbl[i].b, tbl[i].exp, tbl[i].lat);
        end

        // Flush in the 10th CALC cycle.
        op_a = 32'd3; op_b = 32'd5; funct3 = 3'd0; valid_f = 1'b1;
        repeat (10) @(negedge clk);
        chk("busy before flush", {31'b0, busy_f}, 32'd1);
        flush = 1'b1;
        #1;
        chk("stall during flush", {31'b0, stall_f}, 32'd0);
        @(negedge clk);
        chk("busy after flush", {31'b0, busy_f}, 32'd0);
        chk("done after flush", {31'b0, done_f}, 32'd0);
        chk("stall after flush", {31'b0, stall_f}, 32'd0);
        chk("result kept after flush", result_f, last_f);
        flush = 1'b0; valid_f = 1'b0;
        quiet = 1'b1;
        repeat (4) begin
            @(negedge clk);
            if (done_f || busy_f) quiet = 1'b0;
        end
        chk("no done after flush", {31'b0, quiet}, 32'd1);
        run_op(0, 3'd0, 32'd3, 32'd5, 32'd15, 33);

        // Reset pulse mid-CALC, then a fresh op right after release.
        op_a = 32'hFFFFFFFF; op_b = 32'hFFFFFFFF; funct3 = 3'd3; valid_f = 1'b1;
        repeat (5) @(negedge clk);
        chk("busy before reset", {31'b0, busy_f}, 32'd1);
        rst = 1'b1;
        #1;
        chk("busy in reset", {31'b0, busy_f}, 32'd0);
        chk("done in reset", {31'b0, done_f}, 32'd0);
        chk("result in reset", result_f, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        run_op(0, 3'd5, 32'd100, 32'd7, 32'd14, 33);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

endmodule

// File: doc/ex_mdu.md
Name: ex_mdu

Overview:
- Iterative RV32M multiply/divide unit in the EX stage, directly downstream of the ID/EX pipeline register.
- Consumes the operands and funct3 of an M-extension instruction held in EX.
- Drives `stall` so that the hazard logic holds ID/EX (`en` low) and the upstream stages until the result is ready.
- Delivers a 32-bit result to the EX result mux in the cycle the instruction leaves EX.

Parameters:
- WIDTH, 32, operand/result width; iteration count per operation.
- FAST_SPECIAL, 1, when 1 divide-by-zero and signed overflow complete without iterating.

Ports:
- clk  input  1  pipeline clock; all state updates on posedge.
- rst  input  1  asynchronous active-high reset.
- valid_in  input  1  EX holds an M instruction (opcode 0110011, funct7 0000001) that is not a bubble.
- funct3  input  3  0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- op_a  input  WIDTH  rs1 value after forwarding.
- op_b  input  WIDTH  rs2 value after forwarding.
- flush  input  1  EX instruction is killed (branch/jump redirect); synchronous abort.
- stall  output  1  hold ID/EX and earlier stages this cycle.
- busy  output  1  iteration in progress (state CALC).
- done  output  1  result valid this cycle; instruction leaves EX at the next edge.
- result  output  WIDTH  operation result, held stable while done=1.

Behaviour:
- Reset (async, any state): state=IDLE, result=0, done=0, busy=0, all internal accumulators/counters cleared. `stall` follows the combinational rule below.
- `stall = valid_in & ~done & ~flush` (combinational).
- State IDLE: if `valid_in & ~flush`, latch funct3, operand magnitudes and the sign of the result. Go to CALC with count=0.
  - If FAST_SPECIAL=1 and the op is a divide/remainder special case, load the special result and go to DONE instead.
- State CALC: one iteration per cycle.
  - Multiply: shift-add on unsigned magnitudes into a 2*WIDTH product.
  - Divide: restoring division, one quotient bit per cycle.
  - After WIDTH iterations, apply sign correction, select the output, go to DONE.
- State DONE: done=1, result valid, stall=0. Unconditionally return to IDLE next cycle. The new EX instruction is evaluated in IDLE; the completed instruction is never restarted.
- Latency:
  - Accept at cycle T; CALC occupies T+1..T+WIDTH; DONE at T+WIDTH+1.
  - The instruction occupies EX for WIDTH+2 cycles (34 for WIDTH=32).
  - Fast special cases: DONE at T+1, 2 cycles total.
- Sign rules:
  - MULH: both operands signed.
  - MULHSU: op_a signed, op_b unsigned.
  - MULHU, DIVU, REMU: unsigned.
  - MUL returns the low WIDTH bits; the MULH* variants return the high WIDTH bits of the 2*WIDTH product.
  - Negative product: two's complement of the full 2*WIDTH magnitude.
  - Quotient sign = sign(a) XOR sign(b); remainder sign = sign(a).
- Divide by zero:
  - DIV/DIVU quotient = all ones.
  - REM/REMU remainder = op_a.
  - With FAST_SPECIAL=0 the same values emerge from iteration plus sign fixup; they must match bit-exactly.
- Signed overflow (op_a=0x80000000, op_b=-1): DIV returns 0x80000000, REM returns 0.
- flush:
  - In IDLE: no accept.
  - In CALC: abort to IDLE next edge, done stays 0, result unchanged.
  - In DONE: has no effect; completion stands.
- Operands and funct3 are captured at accept. Changes on op_a/op_b (for example late forwarding) during CALC are ignored.
- Reset asserted mid-CALC: immediate IDLE, no done pulse after release.
- `valid_in` low while in CALC (an upstream bubble, which should not happen while stalled): the unit completes anyway; done fires without consumer effect.

Test Plan:
- MUL: op_a=7, op_b=0xFFFFFFFD, accept at T -> stall=1 T..T+32, done=1 only at T+33, result=0xFFFFFFEB, stall=0 at T+33.
- MULHU/MULH: 0xFFFFFFFF*0xFFFFFFFF -> MULHU=0xFFFFFFFE, MULH=0x00000000, MULHSU=0xFFFFFFFF.
- Divide by zero: op_a=0x12345678, op_b=0.
  - FAST_SPECIAL=1 -> done at T+1; DIV=0xFFFFFFFF, REM=0x12345678.
  - FAST_SPECIAL=0 -> same values at T+33.
- Overflow and signs:
  - 0x80000000 / 0xFFFFFFFF -> DIV=0x80000000, REM=0.
  - DIVU 100/7 -> 14, REMU -> 2.
  - DIV -7/2 -> 0xFFFFFFFD, REM -> 0xFFFFFFFF.
- flush at the 10th CALC cycle -> next cycle busy=0, stall=0, done never pulses. A following MUL 3*5 with valid_in back-to-back -> result 15 after 34 cycles.
- rst pulse mid-CALC -> outputs immediately 0/IDLE. After release with valid_in=1, a fresh operation starts and completes with the correct result.
